seq_divider: RTL

//  Sequential restoring shift-subtract divider, unsigned: quotient = dividend / divisor, remainder = dividend % divisor.

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_div_step.sv | 40 ++++
 rtl/seq_divider.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential restoring divider.
//   div_state_t        : controller states (IDLE, CALC, DONE)
//   DIV_WIDTH_DEFAULT  : default operand / result width
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract iteration, purely combinational.
// Shifts the next dividend bit (MSB of Q) into the partial remainder,
// compares at WIDTH+1 bits against the divisor and, if it fits,
// subtracts and sets the new quotient LSB.
// Ports:
//   r_i       : current partial remainder (WIDTH bits)
//   q_i       : current quotient / remaining dividend bits
//   divisor_i : divisor
//   r_o       : next partial remainder
//   q_o       : next quotient
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);

    // The stored remainder is always < divisor, so its (WIDTH+1)th bit is
    // zero between iterations; only the shifted value needs the extra bit.
    logic [WIDTH:0] shifted;
    logic           fits;

    always_comb begin
        shifted = {r_i, q_i[WIDTH-1]};
        fits    = (shifted >= {1'b0, divisor_i});
        if (fits) begin
            r_o = WIDTH'(shifted - {1'b0, divisor_i});
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            r_o = shifted[WIDTH-1:0];
            q_o = {q_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// start/ready/done handshake; results hold until the next finished op.
// Optional feature macro: DIVIDER_ZERO_DETECT_EN
//   defined   : divisor==0 skips CALC, done on the 2nd edge, div_by_zero=1
//   undefined : div_by_zero tied low, divide-by-zero runs full latency
// Ports:
//   clk, reset   : clock (rising edge), synchronous active-high reset
//   start        : request; accepted only while ready=1
//   dividend     : numerator, sampled on the accepted start edge
//   divisor      : denominator, sampled on the accepted start edge
//   ready        : high in IDLE
//   done         : one-cycle pulse when quotient/remainder are valid
//   quotient     : result, held between operations
//   remainder    : result, held between operations
//   div_by_zero  : divisor was zero (feature-dependent)
//
// state | meaning
// IDLE  | waiting for start, ready=1
// CALC  | WIDTH restoring iterations, counter counts down to 0
// DONE  | copy Q/R to the result registers, pulse done on exit
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i       (r_q),
        .q_i       (q_q),
        .divisor_i (dvs_q),
        .r_o       (step_r),
        .q_o       (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d   = divisor;
                    r_d     = '0;
                    q_d     = dividend;
                    cnt_d   = CW'(WIDTH - 1);
                    dbz_d   = 1'b0;
                    state_d = CALC;
`ifdef DIVIDER_ZERO_DETECT_EN
                    // Preload the same answer the full algorithm would give.
                    if (divisor == '0) begin
                        dbz_d   = 1'b1;
                        q_d     = '1;
                        r_d     = dividend;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                r_d = step_r;
                q_d = step_q;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                quot_d  = q_q;
                rem_d   = r_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign ready       = (state_q == IDLE);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
